c_fetch_align_ctrl: RTL

Fetch-side controller for the compressed-extension front end. It sequences word-aligned I-cache requests and keeps a 3-halfword realignment buffer. It hands the decoder exactly one aligned instruction per accepted cycle, either 16-bit or 32-bit, including 32-bit instructions that straddle two fetch words. It sits between the PC/redirect logic and the decode stage.

---
 rtl/c_fetch_pkg.sv | 17 +
 rtl/c_halfword_buf.sv | 88 ++++++++
 rtl/c_fetch_align_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/c_fetch_pkg.sv
// Shared types and helpers for the compressed-extension fetch front end.
package c_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD
  } fetch_state_e;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  // Any halfword whose low two bits are not 2'b11 starts a 16-bit instruction.
  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/c_halfword_buf.sv
// Three-entry halfword realignment buffer: consume-shift, then append, in one cycle.
module c_halfword_buf
  import c_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        consume,
  input  logic        consume_two,
  input  logic        append,
  input  logic        append_two,
  input  logic [31:0] data,
  output logic [15:0] hw0,
  output logic [15:0] hw1,
  output logic [1:0]  cnt,
  output logic [31:0] buf_pc,
  output logic [1:0]  cnt_consumed,
  output logic [1:0]  cnt_next
);

  logic [15:0] buf_q [3];
  logic [15:0] buf_d [3];
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  lo_idx, hi_idx;
  logic [15:0] lo_data;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    buf_d        = buf_q;
    cnt_consumed = cnt_q;
    if (consume) begin
      if (consume_two) begin
        buf_d[0]     = buf_q[2];
        cnt_consumed = cnt_q - 2'd2;
      end else begin
        buf_d[0]     = buf_q[1];
        buf_d[1]     = buf_q[2];
        cnt_consumed = cnt_q - 2'd1;
      end
    end

    // Fetch is only issued with cnt<=1, so an append always fits in three entries.
    lo_idx  = cnt_consumed;
    hi_idx  = cnt_consumed + 2'd1;
    lo_data = append_two ? data[15:0] : data[31:16];
    cnt_d   = cnt_consumed;
    if (append) begin
      cnt_d = append_two ? cnt_consumed + 2'd2 : cnt_consumed + 2'd1;
      for (int i = 0; i < 3; i++) begin
        if (i[1:0] == lo_idx)               buf_d[i] = lo_data;
        if (append_two && i[1:0] == hi_idx) buf_d[i] = data[31:16];
      end
    end
    if (flush) cnt_d = 2'd0;

    pc_d = pc_q;
    if (flush)        pc_d = flush_pc;
    else if (consume) pc_d = pc_q + (consume_two ? 32'd4 : 32'd2);
  end

  assign cnt_next = cnt_d;

  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments.
    if (reset) begin
      cnt_q <= 2'd0;
      pc_q  <= RESET_PC;
    end else begin
      cnt_q <= cnt_d;
      pc_q  <= pc_d;
    end
  end

  // NOTE: storage is deliberately not reset; cnt alone says which entries are meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) buf_q[i] <= buf_d[i];
  end

  assign hw0    = buf_q[0];
  assign hw1    = buf_q[1];
  assign cnt    = cnt_q;
  assign buf_pc = pc_q;

endmodule

// File: rtl/c_fetch_align_ctrl.sv
// Fetch sequencing and instruction realignment for the compressed front end.
// Optional statistics counters are built when C_FETCH_STATS_EN is defined.
module c_fetch_align_ctrl
  import c_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] NOP_INSTR = C_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        icache_req_o,
  output logic [31:0] icache_addr_o,
  output logic        icache_kill_o,
  input  logic        icache_ack_i,
  input  logic [31:0] icache_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_compressed_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i
`ifdef C_FETCH_STATS_EN
  ,
  output logic [31:0] straddle_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_addr_q;
  logic         drop_low_q;
  logic         ack;
  logic [15:0]  hw0, hw1;
  logic [1:0]   cnt, cnt_consumed, cnt_next;
  logic [31:0]  buf_pc;
  logic         head_c, valid, consume;

  // Ack only counts while a request is actually on the bus.
  assign ack     = icache_ack_i && (state_q == S_FETCH);
  assign head_c  = is_compressed(hw0);
  assign valid   = !redirect_i && (cnt != 2'd0) && (head_c || cnt >= 2'd2);
  assign consume = valid && inst_ready_i;

  c_halfword_buf #(.RESET_PC(RESET_PC)) u_buf (
    .clk          (clk),
    .reset        (reset),
    .flush        (redirect_i),
    .flush_pc     (redirect_pc_i),
    .consume      (consume),
    .consume_two  (!head_c),
    .append       (ack && !redirect_i),
    .append_two   (!drop_low_q),
    .data         (icache_data_i),
    .hw0          (hw0),
    .hw1          (hw1),
    .cnt          (cnt),
    .buf_pc       (buf_pc),
    .cnt_consumed (cnt_consumed),
    .cnt_next     (cnt_next)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      state_d = S_FETCH;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_FETCH;
        S_FETCH: if (ack) state_d = (cnt_next <= 2'd1) ? S_FETCH : S_HOLD;
        S_HOLD:  if (cnt_consumed <= 2'd1) state_d = S_FETCH;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    icache_req_o  = (state_q == S_FETCH);
    icache_kill_o = redirect_i && (state_q == S_FETCH) && !icache_ack_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_addr_q <= RESET_PC;
      drop_low_q   <= 1'b0;
    end else if (redirect_i) begin
      fetch_addr_q <= {redirect_pc_i[31:2], 2'b00};
      drop_low_q   <= redirect_pc_i[1];
    end else if (ack) begin
      fetch_addr_q <= fetch_addr_q + 32'd4;
      drop_low_q   <= 1'b0;
    end
  end

  assign icache_addr_o     = fetch_addr_q;
  assign inst_valid_o      = valid;
  assign inst_compressed_o = valid && head_c;
  assign inst_pc_o         = valid ? buf_pc : 32'd0;
  assign inst_o            = !valid ? NOP_INSTR : head_c ? {16'h0000, hw0} : {hw1, hw0};

`ifdef C_FETCH_STATS_EN
  // A 32-bit instruction straddles fetch words exactly when it starts on an odd halfword.
  always_ff @(posedge clk) begin
    if (reset) begin
      straddle_cnt_o <= 32'd0;
      stall_cnt_o    <= 32'd0;
    end else begin
      if (consume && !head_c && buf_pc[1] && straddle_cnt_o != '1)
        straddle_cnt_o <= straddle_cnt_o + 32'd1;
      if (inst_ready_i && !valid && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
